serial_frame_receiver: RTL
==========================

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the idle cycles allowed between strobes mid-frame before abort; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port btn_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_in  input  1  serial data, synchronous to clk (holding-register LSB stream).
REQ-005 SHALL have port bit_strobe  input  1  one-cycle pulse; bit_in sampled in that cycle only.
REQ-006 SHALL have port clear_err  input  1  synchronous clear of sticky error flags.
REQ-007 SHALL have port rx_data  output  8  last accepted byte.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse per accepted byte.
REQ-009 SHALL have port rx_count  output  8  accepted-byte counter.
REQ-010 SHALL have port frame_err  output  1  sticky stop-bit/timeout error.
REQ-011 SHALL have port parity_err  output  1  sticky parity error.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame format SHALL be: start bit 1, 8 data bits LSB first, optional even-parity bit, stop bit 0; idle line is 0.
REQ-014 States SHALL be IDLE, DATA, PARITY, STOP; transitions only in cycles with bit_strobe=1 (timeout excepted).
REQ-015 IDLE: strobe with bit_in=1 -> DATA, bit index 0; strobe with bit_in=0 -> stay IDLE, no error.
REQ-016 DATA: each strobe stores bit_in at index, increments index; after 8th bit -> PARITY if enabled, else STOP.
REQ-017 PARITY: strobe captures bit; error if XOR of 8 data bits and parity bit is 1; -> STOP.
REQ-018 STOP: strobe with bit_in=0 and no parity error -> rx_data updated, rx_valid pulses next cycle, rx_count+1; -> IDLE.
REQ-019 STOP: strobe with bit_in=1 -> frame_err set, byte discarded, rx_data unchanged, -> IDLE.
REQ-020 Parity error SHALL set parity_err, discard byte, rx_count unchanged, -> IDLE at stop strobe regardless of stop value.
REQ-021 rx_valid latency SHALL be exactly 1 cycle after the accepting stop strobe; width exactly 1 cycle.
REQ-022 rx_count SHALL wrap 255 -> 0 without flag.
REQ-023 Timeout: counter reset on every strobe; in non-IDLE state, reaching TIMEOUT_CYCLES with no strobe SHALL set frame_err and return to IDLE.
REQ-024 clear_err SHALL clear both flags next cycle; a simultaneous new error SHALL win (flag stays set).
REQ-025 Strobes on consecutive cycles SHALL each be accepted; no minimum spacing.

Reset
REQ-026 btn_reset=0 SHALL immediately force IDLE, rx_data=0, rx_valid=0, rx_count=0, frame_err=0, parity_err=0, busy=0, index and timeout counter 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; first strobe after release is treated as IDLE input.

Configuration
REQ-028 Macro SERIAL_RX_PARITY_EN defined: PARITY state present, parity checked per REQ-017/020.
REQ-029 Macro undefined: PARITY state absent, DATA -> STOP directly, parity_err tied 0.

Structure
REQ-030 Shared package SHALL hold state encoding constants, frame bit constants (START=1, STOP=0), data width 8.
REQ-031 One sub-module, rx_timeout_counter (strobe-cleared counter with expiry pulse), SHALL be instantiated; remainder flat.

Verification
REQ-032 Strobe sequence 1,[0,1,0,1,1,0,1,0],0 (parity 0 if enabled) -> rx_data=0x5A, one rx_valid pulse, rx_count=1.
REQ-033 Frame for 0xFF with stop bit 1 -> frame_err=1, rx_count unchanged, busy=0 after stop strobe; clear_err -> 0.
REQ-034 SERIAL_RX_PARITY_EN, 0x01 with parity bit 0 -> parity_err=1, no rx_valid.
REQ-035 TIMEOUT_CYCLES=16, start bit then 3 data bits then 16 idle cycles -> frame_err=1, IDLE; next full 0x3C frame accepted.
REQ-036 256 valid frames -> rx_count wraps to 0; btn_reset low during 5th data bit -> all outputs 0 immediately.

Source files
------------

// File: rtl/serial_frame_receiver_pkg.sv
// Shared constants for the serial frame receiver: state encoding, frame bit levels, data width.
// Optional parity support is selected with the SERIAL_RX_PARITY_EN macro in the top module.
package serial_frame_receiver_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_frame_receiver_timeout.sv
// rx_timeout_counter: counts idle cycles between strobes while enabled and pulses
// expired on the cycle the count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 disables it.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TO_ON = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt;

  // A strobe in the same cycle always wins over expiry.
  assign expired = TO_ON && enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Strobe-driven serial frame receiver: start(1), 8 data bits LSB first, optional even
// parity (SERIAL_RX_PARITY_EN), stop(0). Sticky frame/parity errors, idle timeout abort.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              btn_reset,
  input  logic              bit_in,
  input  logic              bit_strobe,
  input  logic              clear_err,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_count,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  rx_state_t         state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift_reg;
  logic              timeout_hit;
  logic              par_bad;

`ifdef SERIAL_RX_PARITY_EN
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  rx_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (btn_reset),
    .clear   (bit_strobe),
    .enable  (busy),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_count  <= '0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      // Clear first so that an error raised later in this same cycle wins.
      if (clear_err) begin
        frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      if (timeout_hit) begin
        state     <= ST_IDLE;
        idx       <= '0;
        frame_err <= 1'b1;
      end else if (bit_strobe) begin
        case (state)
          ST_IDLE: begin
            if (bit_in == START_BIT) begin
              state <= ST_DATA;
              idx   <= '0;
`ifdef SERIAL_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end
          end
          ST_DATA: begin
            shift_reg[idx] <= bit_in;
            idx            <= idx + 1'b1;
            if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          ST_PARITY: begin
            par_bad <= (^shift_reg) ^ bit_in;
            if ((^shift_reg) ^ bit_in) begin
              parity_err_q <= 1'b1;
            end
            state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            // A parity failure discards the byte whatever the stop level.
            if (!par_bad) begin
              if (bit_in == STOP_BIT) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                rx_count <= rx_count + 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
            state <= ST_IDLE;
            idx   <= '0;
          end
          default: begin
            state <= ST_IDLE;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule
